// File: rtl/rambyte_arbiter_pkg.sv
// Shared types and constants for the two-port block-RAM byte arbiter.
package rambyte_arbiter_pkg;

    localparam int unsigned RAMBYTE_AW = 14;
    localparam int unsigned RAMBYTE_DW = 8;
    localparam int unsigned HOLD_W     = 8;
    localparam int unsigned PORT0      = 0;
    localparam int unsigned PORT1      = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rambyte_arb_pick.sv
// Combinational two-way grant selection for rambyte_arbiter.
// RAMBYTE_ARB_RR_EN selects alternating contested grants instead of fixed priority.
module rambyte_arb_pick
    import rambyte_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic              req0,
    input  logic              req1,
    input  arb_state_t        state,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  logic              owner_last,
    output logic              gnt0,
    output logic              gnt1
);

    logic at_max;
    logic pick1;
    logic unused_sel;

    assign at_max = (hold_cnt == HOLD_W'(MAX_HOLD));

`ifdef RAMBYTE_ARB_RR_EN
    // Contested cycles go to whichever port was not granted last.
    assign pick1      = (owner_last == 1'(PORT0));
    assign unused_sel = at_max;
`else
    assign pick1      = at_max;
    assign unused_sel = owner_last;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ST_LOCK0: gnt0 = req0;
            ST_LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = !pick1;
                    gnt1 = pick1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/rambyte_arbiter.sv
// Two-requester access controller for a single-port 16K x 8 block RAM.
// Build option: RAMBYTE_ARB_RR_EN (round-robin contested grants; default fixed priority port 0).
module rambyte_arbiter
    import rambyte_arbiter_pkg::*;
#(
    parameter int unsigned AW       = RAMBYTE_AW,
    parameter int unsigned DW       = RAMBYTE_DW,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner_last;

    rambyte_arb_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .req0       (req0),
        .req1       (req1),
        .state      (state),
        .hold_cnt   (hold_cnt),
        .owner_last (owner_last),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // RAM port mux: the granted requester drives the array, idle cycles drive zeros.
    always_comb begin
        ram_en   = gnt0 | gnt1;
        ram_we   = (gnt0 & we0) | (gnt1 & we1);
        ram_addr = '0;
        ram_di   = '0;
        if (gnt1) begin
            ram_addr = addr1;
            ram_di   = wdata1;
        end else if (gnt0) begin
            ram_addr = addr0;
            ram_di   = wdata0;
        end
    end

    assign rdata0 = rvalid0 ? ram_do : '0;
    assign rdata1 = rvalid1 ? ram_do : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            owner_last <= 1'(PORT0);
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;

            if (gnt0)      owner_last <= 1'(PORT0);
            else if (gnt1) owner_last <= 1'(PORT1);

            case (state)
                ST_IDLE: begin
                    if (gnt0 && lock0)      state <= ST_LOCK0;
                    else if (gnt1 && lock1) state <= ST_LOCK1;
                end
                ST_LOCK0: if (!req0 || !lock0) state <= ST_IDLE;
                ST_LOCK1: if (!req1 || !lock1) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

`ifdef RAMBYTE_ARB_RR_EN
            hold_cnt <= '0;
`else
            // Counts contested wins of port 0; saturation hands the next contested cycle to port 1.
            if (gnt1 || !req1)
                hold_cnt <= '0;
            else if (gnt0 && hold_cnt != HOLD_W'(MAX_HOLD))
                hold_cnt <= HOLD_W'(hold_cnt + 1'b1);
`endif
        end
    end

endmodule

// File: tb/tb_rambyte_arbiter.sv
// Self-checking bench for rambyte_arbiter: directed scenarios plus random two-port traffic
// against a byte-array reference model.
module tb_rambyte_arbiter;

    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXH = 3;

    logic          CLK;
    logic          RST;
    logic          p_req  [2];
    logic          p_we   [2];
    logic          p_lock [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd   [2];
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];

    int checks;
    int errors;

    rambyte_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAXH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req0     (p_req[0]),
        .req1     (p_req[1]),
        .we0      (p_we[0]),
        .we1      (p_we[1]),
        .lock0    (p_lock[0]),
        .lock1    (p_lock[1]),
        .addr0    (p_addr[0]),
        .addr1    (p_addr[1]),
        .wdata0   (p_wd[0]),
        .wdata1   (p_wd[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural single-port RAM with 1-cycle synchronous read.
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_di;
            else        ram_do <= ram_mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            p_req[p]  = 1'b0;
            p_we[p]   = 1'b0;
            p_lock[p] = 1'b0;
            p_addr[p] = '0;
            p_wd[p]   = '0;
        end
    endtask

    task automatic drive(input int p, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[p]  = 1'b1;
        p_we[p]   = we;
        p_lock[p] = lk;
        p_addr[p] = a;
        p_wd[p]   = d;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (3) step();
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, ram_en, ram_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {gnt0, gnt1, ram_en, ram_we});
        end
        checks++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_rd: rvalid=%b%b rdata0=%h rdata1=%h want zeros", rvalid0, rvalid1, rdata0, rdata1);
        end
        checks++;
        if ({ram_addr, ram_di} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h di=%h want 0", ram_addr, ram_di);
        end
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        drive(1, 1'b1, 1'b0, 14'h0123, 8'hA5);
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, ram_en, ram_we, ram_addr, ram_di} !== {4'b0111, 14'h0123, 8'hA5}) begin
            errors++;
            $display("FAIL wr1_bus: gnt=%b%b en=%b we=%b addr=%h di=%h want 0 1 1 1 0123 a5",
                     gnt0, gnt1, ram_en, ram_we, ram_addr, ram_di);
        end
        step();
        drive(1, 1'b0, 1'b0, 14'h0123, 8'h00);
        @(negedge CLK);
        checks++;
        if ({gnt1, ram_we, rvalid1} !== 3'b100) begin
            errors++;
            $display("FAIL rd1_gnt: gnt1=%b ram_we=%b rvalid1=%b want 1 0 0", gnt1, ram_we, rvalid1);
        end
        step();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if ({rvalid1, rdata1, rvalid0, rdata0} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rd1_data: rvalid1=%b rdata1=%h rvalid0=%b rdata0=%h want 1 a5 0 00",
                     rvalid1, rdata1, rvalid0, rdata0);
        end
        step();
    endtask

    task automatic test_hold();
        logic exp1;
        drive(0, 1'b0, 1'b0, 14'h0200, 8'h00);
        drive(1, 1'b0, 1'b0, 14'h0201, 8'h00);
        for (int i = 0; i < 8; i++) begin
`ifdef RAMBYTE_ARB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = (i % (MAXH + 1)) == MAXH;
`endif
            @(negedge CLK);
            checks++;
            if ({gnt0, gnt1} !== {!exp1, exp1}) begin
                errors++;
                $display("FAIL hold_seq[%0d]: gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, !exp1, exp1);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lock();
        drive(1, 1'b0, 1'b1, 14'h0010, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if ({gnt0, gnt1, ram_addr} !== {2'b01, 14'(16'h0010 + i)}) begin
                errors++;
                $display("FAIL lock1[%0d]: gnt0=%b gnt1=%b addr=%h want 0 1 %h",
                         i, gnt0, gnt1, ram_addr, 14'(16'h0010 + i));
            end
            step();
            drive(0, 1'b0, 1'b0, 14'h0040, 8'h00);
            if (i < 3) drive(1, 1'b0, (i < 2), 14'(16'h0011 + i), 8'h00);
            else       p_req[1] = 1'b0;
        end
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL lock1_release: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_same_addr();
        drive(0, 1'b1, 1'b0, 14'h0020, 8'h33);
        step();
        drive(0, 1'b0, 1'b0, 14'h0020, 8'h00);
        drive(1, 1'b1, 1'b0, 14'h0020, 8'h5A);
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL same_contest: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        end
        step();
        p_req[0] = 1'b0;
        @(negedge CLK);
        checks++;
        if ({gnt1, ram_we, rvalid0, rdata0} !== {3'b111, 8'h33}) begin
            errors++;
            $display("FAIL same_old: gnt1=%b we=%b rvalid0=%b rdata0=%h want 1 1 1 33",
                     gnt1, ram_we, rvalid0, rdata0);
        end
        step();
        idle_inputs();
        drive(0, 1'b0, 1'b0, 14'h0020, 8'h00);
        step();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if ({rvalid0, rdata0} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL same_new: rvalid0=%b rdata0=%h want 1 5a", rvalid0, rdata0);
        end
        step();
    endtask

    task automatic test_reset_lock();
        drive(0, 1'b0, 1'b1, 14'h0020, 8'h00);
        step();
        drive(1, 1'b0, 1'b0, 14'h0123, 8'h00);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({gnt0, gnt1, ram_en} !== 3'b101) begin
            errors++;
            $display("FAIL rst_lock_gnt: gnt0=%b gnt1=%b en=%b want 1 0 1", gnt0, gnt1, ram_en);
        end
        step();
        RST = 1'b0;
        p_req[0]  = 1'b0;
        p_lock[0] = 1'b0;
        @(negedge CLK);
        checks++;
        if ({rvalid0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL rst_lock_after: rvalid0=%b gnt1=%b want 0 1", rvalid0, gnt1);
        end
        step();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL rst_lock_rd: rvalid1=%b rdata1=%h want 1 a5", rvalid1, rdata1);
        end
        step();
    endtask

    task automatic test_random();
        int   lk;      // 0 none, 1 port 0 owns, 2 port 1 owns
        int   hold;
        int   last;
        int   waitc [2];
        logic pend  [2];
        logic eg    [2];
        logic erv   [2];
        logic [DW-1:0] erd [2];
        logic [DW-1:0] d;

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            drive(0, 1'b1, 1'b0, 14'(16'h0100 + i), d);
            ref_mem[16'h0100 + i] = d;
            step();
        end
        idle_inputs();
        step();

        lk = 0; hold = 0; last = 0;
        for (int p = 0; p < 2; p++) begin
            waitc[p] = 0; pend[p] = 1'b0; erv[p] = 1'b0; erd[p] = '0;
        end

        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 3) != 0) begin
                    pend[p] = 1'b1;
                    drive(p, 1'($urandom), (($urandom % 4) == 0),
                          14'(32'h0100 + $urandom_range(15, 0)), 8'($urandom));
                end else if (!pend[p]) begin
                    p_req[p]  = 1'b0;
                    p_lock[p] = 1'($urandom);
                end
            end

            eg[0] = 1'b0;
            eg[1] = 1'b0;
            if (lk == 1)      eg[0] = p_req[0];
            else if (lk == 2) eg[1] = p_req[1];
            else if (p_req[0] && p_req[1]) begin
`ifdef RAMBYTE_ARB_RR_EN
                if (last == 0) eg[1] = 1'b1; else eg[0] = 1'b1;
`else
                if (hold == MAXH) eg[1] = 1'b1; else eg[0] = 1'b1;
`endif
            end else begin
                eg[0] = p_req[0];
                eg[1] = p_req[1];
            end

            @(negedge CLK);
            checks++;
            if ({gnt0, gnt1} !== {eg[0], eg[1]}) begin
                errors++;
                $display("FAIL rand_gnt c=%0d: gnt0=%b gnt1=%b want %b %b", c, gnt0, gnt1, eg[0], eg[1]);
            end
            checks++;
            if ({rvalid0, rdata0, rvalid1, rdata1} !== {erv[0], erd[0], erv[1], erd[1]}) begin
                errors++;
                $display("FAIL rand_rd c=%0d: rv0=%b rd0=%h rv1=%b rd1=%h want %b %h %b %h",
                         c, rvalid0, rdata0, rvalid1, rdata1, erv[0], erd[0], erv[1], erd[1]);
            end

            for (int p = 0; p < 2; p++) begin
                erv[p] = eg[p] && !p_we[p];
                erd[p] = erv[p] ? ref_mem[int'(p_addr[p])] : '0;
                if (eg[p] && p_we[p]) ref_mem[int'(p_addr[p])] = p_wd[p];
                if (eg[p]) begin
                    checks++;
                    if (waitc[p] > int'(MAXH) + 1) begin
                        errors++;
                        $display("FAIL rand_starve c=%0d port%0d: waited %0d want <= %0d",
                                 c, p, waitc[p], MAXH + 1);
                    end
                    waitc[p] = 0;
                end else if (p_req[p] && lk != 2 - p) begin
                    waitc[p]++;
                end
            end

            if (lk == 1) begin
                if (!p_req[0] || !p_lock[0]) lk = 0;
            end else if (lk == 2) begin
                if (!p_req[1] || !p_lock[1]) lk = 0;
            end else if (eg[0] && p_lock[0]) lk = 1;
            else if (eg[1] && p_lock[1])     lk = 2;

            if (eg[1] || !p_req[1])          hold = 0;
            else if (eg[0] && hold < int'(MAXH)) hold++;
            if (eg[0]) last = 0;
            else if (eg[1]) last = 1;

            step();
            for (int p = 0; p < 2; p++)
                if (eg[p]) pend[p] = 1'b0;
        end
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_hold();
        test_lock();
        test_same_addr();
        test_reset_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
